// File: rtl/ex_operand_if.sv
// ID/EX operand-stage bus: decoded ID fields, MEM/WB forwarding sources,
// the EX-side operands and controls, and the IF/ID stall outputs.
interface ex_operand_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [XLEN-1:0]   id_rd1;
    logic [XLEN-1:0]   id_rd2;
    logic [XLEN-1:0]   id_imm;
    logic [2:0]        id_alu_control;
    logic              id_alu_src;
    logic              id_reg_dst;
    logic              id_reg_write;
    logic              id_mem_to_reg;
    logic              id_mem_write;

    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_write_reg;
    logic [XLEN-1:0]   mem_alu_result;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_write_reg;
    logic [XLEN-1:0]   wb_result;
    logic              flush_e;

    logic              stall_f;
    logic              stall_d;
    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   src_b;
    logic [2:0]        alu_control;
    logic [XLEN-1:0]   ex_write_data;
    logic [REG_AW-1:0] ex_write_reg;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_mem_to_reg;
    logic              ex_mem_write;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm,
               id_alu_control, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_to_reg, id_mem_write,
               mem_reg_write, mem_write_reg, mem_alu_result,
               wb_reg_write, wb_write_reg, wb_result, flush_e,
        input  stall_f, stall_d, src_a, src_b, alu_control, ex_write_data,
               ex_write_reg, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm,
               id_alu_control, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_to_reg, id_mem_write,
               mem_reg_write, mem_write_reg, mem_alu_result,
               wb_reg_write, wb_write_reg, wb_result, flush_e,
        output stall_f, stall_d, src_a, src_b, alu_control, ex_write_data,
               ex_write_reg, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use stall
// detection feeding the execute-stage ALU.
module ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic         clk,
    input logic         reset,
    ex_operand_if.slave bus
);
    logic              valid_p1;
    logic              reg_write_p1;
    logic              mem_to_reg_p1;
    logic              mem_write_p1;
    logic              alu_src_p1;
    logic [2:0]        alu_control_p1;
    logic [REG_AW-1:0] rs_p1;
    logic [REG_AW-1:0] rt_p1;
    logic [REG_AW-1:0] write_reg_p1;
    logic [XLEN-1:0]   rd1_p1;
    logic [XLEN-1:0]   rd2_p1;
    logic [XLEN-1:0]   imm_p1;

    logic              load_use;
    logic              bubble;
    logic [XLEN-1:0]   fwd_a;
    logic [XLEN-1:0]   fwd_b;

    // Newest producer wins; $0 is hardwired so it is never forwarded.
    function automatic logic [XLEN-1:0] forward(
        input logic [REG_AW-1:0] idx,
        input logic [XLEN-1:0]   reg_val,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_idx,
        input logic [XLEN-1:0]   mem_val,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_idx,
        input logic [XLEN-1:0]   wb_val
    );
        if (mem_we && (mem_idx != '0) && (mem_idx == idx)) return mem_val;
        if (wb_we && (wb_idx != '0) && (wb_idx == idx)) return wb_val;
        return reg_val;
    endfunction

    always_comb begin
        load_use = valid_p1 && mem_to_reg_p1 && (write_reg_p1 != '0) && bus.id_valid &&
                   ((bus.id_rs == write_reg_p1) || (bus.id_rt == write_reg_p1));
        bubble   = reset || bus.flush_e || load_use;
    end

    // ID -> EX boundary
    always_ff @(posedge clk) begin
        if (bubble) begin
            valid_p1       <= 1'b0;
            reg_write_p1   <= 1'b0;
            mem_to_reg_p1  <= 1'b0;
            mem_write_p1   <= 1'b0;
            alu_src_p1     <= 1'b0;
            alu_control_p1 <= 3'b000;
            rs_p1          <= '0;
            rt_p1          <= '0;
            write_reg_p1   <= '0;
            rd1_p1         <= '0;
            rd2_p1         <= '0;
            imm_p1         <= '0;
        end else begin
            valid_p1       <= bus.id_valid;
            reg_write_p1   <= bus.id_reg_write && bus.id_valid;
            mem_to_reg_p1  <= bus.id_mem_to_reg && bus.id_valid;
            mem_write_p1   <= bus.id_mem_write && bus.id_valid;
            alu_src_p1     <= bus.id_alu_src;
            alu_control_p1 <= bus.id_alu_control;
            rs_p1          <= bus.id_rs;
            rt_p1          <= bus.id_rt;
            write_reg_p1   <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            rd1_p1         <= bus.id_rd1;
            rd2_p1         <= bus.id_rd2;
            imm_p1         <= bus.id_imm;
        end
    end

    // EX operand selection
    always_comb begin
        fwd_a = forward(rs_p1, rd1_p1, bus.mem_reg_write, bus.mem_write_reg,
                        bus.mem_alu_result, bus.wb_reg_write, bus.wb_write_reg, bus.wb_result);
        fwd_b = forward(rt_p1, rd2_p1, bus.mem_reg_write, bus.mem_write_reg,
                        bus.mem_alu_result, bus.wb_reg_write, bus.wb_write_reg, bus.wb_result);
    end

    assign bus.src_a         = fwd_a;
    assign bus.src_b         = alu_src_p1 ? imm_p1 : fwd_b;
    assign bus.ex_write_data = fwd_b;
    assign bus.stall_f       = load_use;
    assign bus.stall_d       = load_use;
    assign bus.alu_control   = alu_control_p1;
    assign bus.ex_write_reg  = write_reg_p1;
    assign bus.ex_valid      = valid_p1;
    assign bus.ex_reg_write  = reg_write_p1;
    assign bus.ex_mem_to_reg = mem_to_reg_p1;
    assign bus.ex_mem_write  = mem_write_p1;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed hazard scenarios plus a
// randomized run compared against an instruction-slot reference model.
module tb_ex_operand_stage;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ex_operand_if #(.XLEN(32), .REG_AW(5)) bus ();

    ex_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction currently occupying EX.
    typedef struct {
        logic        valid, reg_write, mem_to_reg, mem_write, alu_src;
        logic [2:0]  alu_control;
        logic [4:0]  rs, rt, wreg;
        logic [31:0] rd1, rd2, imm;
    } slot_t;
    slot_t ex;

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.reg_write = 0; s.mem_to_reg = 0; s.mem_write = 0; s.alu_src = 0;
        s.alu_control = 3'b000; s.rs = 0; s.rt = 0; s.wreg = 0;
        s.rd1 = 0; s.rd2 = 0; s.imm = 0;
        return s;
    endfunction

    // A load in EX whose result the ID instruction reads must wait a cycle.
    function automatic logic model_stall();
        if (!(ex.valid && ex.mem_to_reg) || ex.wreg == 0 || !bus.id_valid) return 1'b0;
        return (bus.id_rs == ex.wreg) || (bus.id_rt == ex.wreg);
    endfunction

    // Value the architectural register idx holds as seen by EX.
    function automatic logic [31:0] model_operand(input logic [4:0] idx, input logic [31:0] file_val);
        if (idx == 0) return file_val;
        if (bus.mem_reg_write && bus.mem_write_reg == idx) return bus.mem_alu_result;
        if (bus.wb_reg_write && bus.wb_write_reg == idx) return bus.wb_result;
        return file_val;
    endfunction

    task automatic tick();
        slot_t nx;
        if (reset || bus.flush_e || model_stall()) begin
            nx = empty_slot();
        end else begin
            nx.valid       = bus.id_valid;
            nx.reg_write   = bus.id_valid & bus.id_reg_write;
            nx.mem_to_reg  = bus.id_valid & bus.id_mem_to_reg;
            nx.mem_write   = bus.id_valid & bus.id_mem_write;
            nx.alu_src     = bus.id_alu_src;
            nx.alu_control = bus.id_alu_control;
            nx.rs          = bus.id_rs;
            nx.rt          = bus.id_rt;
            nx.wreg        = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            nx.rd1         = bus.id_rd1;
            nx.rd2         = bus.id_rd2;
            nx.imm         = bus.id_imm;
        end
        @(posedge clk);
        #1;
        ex = nx;
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
        bus.id_rd1 = 0; bus.id_rd2 = 0; bus.id_imm = 0; bus.id_alu_control = 3'b000;
        bus.id_alu_src = 0; bus.id_reg_dst = 0; bus.id_reg_write = 0;
        bus.id_mem_to_reg = 0; bus.id_mem_write = 0;
        bus.mem_reg_write = 0; bus.mem_write_reg = 0; bus.mem_alu_result = 0;
        bus.wb_reg_write = 0; bus.wb_write_reg = 0; bus.wb_result = 0;
        bus.flush_e = 0;
    endtask

    task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                               input logic [2:0] op, input logic alu_src, input logic reg_dst,
                               input logic reg_write, input logic mem_to_reg, input logic mem_write);
        bus.id_valid = 1; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_rd1 = rd1; bus.id_rd2 = rd2; bus.id_imm = imm; bus.id_alu_control = op;
        bus.id_alu_src = alu_src; bus.id_reg_dst = reg_dst; bus.id_reg_write = reg_write;
        bus.id_mem_to_reg = mem_to_reg; bus.id_mem_write = mem_write;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        tick(); tick();
        if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_write} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000",
                {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_write});
        end
        checks++;
        if (bus.src_a !== 0 || bus.src_b !== 0 || bus.ex_write_data !== 0 || bus.stall_d !== 0) begin
            errors++; $display("FAIL reset_data got a=%h b=%h wd=%h stall=%b want zeros",
                bus.src_a, bus.src_b, bus.ex_write_data, bus.stall_d);
        end
        checks++;
        // add $3,$1,$2 loaded, then a reset edge must clear it
        reset = 0;
        drive_instr(5'd1, 5'd2, 5'd3, 32'h10, 32'h20, 32'h0, 3'b010, 0, 1, 1, 0, 0);
        tick();
        if (bus.ex_write_reg !== 5'd3 || bus.ex_valid !== 1'b1 || bus.src_a !== 32'h10) begin
            errors++; $display("FAIL add_load got wreg=%0d valid=%b a=%h want 3 1 00000010",
                bus.ex_write_reg, bus.ex_valid, bus.src_a);
        end
        checks++;
        reset = 1;
        tick();
        reset = 0; idle(); #1;
        if (bus.ex_valid !== 0 || bus.ex_reg_write !== 0 || bus.src_a !== 0 ||
            bus.src_b !== 0 || bus.ex_write_reg !== 0) begin
            errors++; $display("FAIL reset_after_add got valid=%b rw=%b a=%h b=%h wreg=%0d want all 0",
                bus.ex_valid, bus.ex_reg_write, bus.src_a, bus.src_b, bus.ex_write_reg);
        end
        checks++;
    endtask

    task automatic test_forward_priority();
        idle();
        drive_instr(5'd5, 5'd6, 5'd7, 32'h1, 32'h2, 32'h0, 3'b110, 0, 1, 1, 0, 0);
        tick();
        idle();
        bus.mem_reg_write = 1; bus.mem_write_reg = 5'd5; bus.mem_alu_result = 32'h11;
        bus.wb_reg_write = 1; bus.wb_write_reg = 5'd5; bus.wb_result = 32'h22;
        #1;
        if (bus.src_a !== 32'h11) begin
            errors++; $display("FAIL fwd_mem_over_wb got %h want 00000011", bus.src_a);
        end
        checks++;
        bus.mem_reg_write = 0; #1;
        if (bus.src_a !== 32'h22) begin
            errors++; $display("FAIL fwd_wb got %h want 00000022", bus.src_a);
        end
        checks++;
        bus.wb_reg_write = 0; #1;
        if (bus.src_a !== 32'h1 || bus.src_b !== 32'h2) begin
            errors++; $display("FAIL fwd_none got a=%h b=%h want 00000001 00000002", bus.src_a, bus.src_b);
        end
        checks++;
        bus.wb_reg_write = 1; bus.wb_write_reg = 5'd6; bus.wb_result = 32'h66; #1;
        if (bus.src_b !== 32'h66 || bus.ex_write_data !== 32'h66 || bus.src_a !== 32'h1) begin
            errors++; $display("FAIL fwd_wb_rt got b=%h wd=%h a=%h want 00000066 00000066 00000001",
                bus.src_b, bus.ex_write_data, bus.src_a);
        end
        checks++;
    endtask

    task automatic test_zero_index();
        idle();
        drive_instr(5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 3'b000, 0, 1, 1, 0, 0);
        tick();
        idle();
        bus.mem_reg_write = 1; bus.mem_write_reg = 5'd0; bus.mem_alu_result = 32'hDEAD;
        bus.wb_reg_write = 1; bus.wb_write_reg = 5'd0; bus.wb_result = 32'hBEEF;
        #1;
        if (bus.src_a !== 32'h0 || bus.src_b !== 32'h0) begin
            errors++; $display("FAIL zero_no_fwd got a=%h b=%h want 0 0", bus.src_a, bus.src_b);
        end
        checks++;
    endtask

    task automatic test_load_use();
        idle();
        // lw $8, 4($1)
        drive_instr(5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 3'b010, 1, 0, 1, 1, 0);
        tick();
        // add $9,$8,$2 sits in ID
        drive_instr(5'd8, 5'd2, 5'd9, 32'h77, 32'h5, 32'h0, 3'b010, 0, 1, 1, 0, 0);
        #1;
        if (bus.stall_f !== 1'b1 || bus.stall_d !== 1'b1) begin
            errors++; $display("FAIL lu_stall got f=%b d=%b want 1 1", bus.stall_f, bus.stall_d);
        end
        checks++;
        tick();
        if (bus.ex_valid !== 1'b0 || bus.stall_d !== 1'b0) begin
            errors++; $display("FAIL lu_bubble got valid=%b stall=%b want 0 0", bus.ex_valid, bus.stall_d);
        end
        checks++;
        bus.wb_reg_write = 1; bus.wb_write_reg = 5'd8; bus.wb_result = 32'hCAFE0001;
        tick();
        if (bus.ex_valid !== 1'b1 || bus.src_a !== 32'hCAFE0001 || bus.ex_write_reg !== 5'd9) begin
            errors++; $display("FAIL lu_resume got valid=%b a=%h wreg=%0d want 1 cafe0001 9",
                bus.ex_valid, bus.src_a, bus.ex_write_reg);
        end
        checks++;
        // reset arriving while stalled
        idle();
        drive_instr(5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 3'b010, 1, 0, 1, 1, 0);
        tick();
        drive_instr(5'd3, 5'd8, 5'd9, 32'h1, 32'h2, 32'h0, 3'b010, 0, 1, 1, 0, 0);
        reset = 1; #1;
        if (bus.stall_d !== 1'b1) begin
            errors++; $display("FAIL lu_reset_stall got %b want 1", bus.stall_d);
        end
        checks++;
        tick();
        reset = 0; #1;
        if (bus.stall_d !== 1'b0 || bus.ex_mem_to_reg !== 1'b0) begin
            errors++; $display("FAIL lu_reset_drop got stall=%b m2r=%b want 0 0", bus.stall_d, bus.ex_mem_to_reg);
        end
        checks++;
    endtask

    task automatic test_load_use_flush();
        idle();
        drive_instr(5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 3'b010, 1, 0, 1, 1, 0);
        tick();
        drive_instr(5'd8, 5'd2, 5'd9, 32'h77, 32'h5, 32'h0, 3'b010, 0, 1, 1, 0, 0);
        bus.flush_e = 1; #1;
        if (bus.stall_d !== 1'b1 || bus.stall_f !== 1'b1) begin
            errors++; $display("FAIL flush_stall got f=%b d=%b want 1 1", bus.stall_f, bus.stall_d);
        end
        checks++;
        tick();
        bus.flush_e = 0; #1;
        if (bus.ex_reg_write !== 1'b0 || bus.ex_valid !== 1'b0) begin
            errors++; $display("FAIL flush_bubble got rw=%b valid=%b want 0 0", bus.ex_reg_write, bus.ex_valid);
        end
        checks++;
    endtask

    task automatic test_imm_store();
        idle();
        // sw $6, -4($1)
        drive_instr(5'd1, 5'd6, 5'd0, 32'h200, 32'h1, 32'hFFFFFFFC, 3'b010, 1, 0, 0, 0, 1);
        tick();
        idle();
        bus.mem_reg_write = 1; bus.mem_write_reg = 5'd6; bus.mem_alu_result = 32'h55;
        #1;
        if (bus.src_b !== 32'hFFFFFFFC || bus.ex_write_data !== 32'h55 || bus.ex_mem_write !== 1'b1) begin
            errors++; $display("FAIL imm_store got b=%h wd=%h mw=%b want fffffffc 00000055 1",
                bus.src_b, bus.ex_write_data, bus.ex_mem_write);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [31:0] exp_b;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            bus.id_valid = ($urandom_range(0, 3) != 0);
            bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
            bus.id_rd = 5'($urandom_range(0, 3));
            bus.id_rd1 = $urandom; bus.id_rd2 = $urandom; bus.id_imm = $urandom;
            bus.id_alu_control = 3'($urandom); bus.id_alu_src = 1'($urandom);
            bus.id_reg_dst = 1'($urandom); bus.id_reg_write = 1'($urandom);
            bus.id_mem_to_reg = ($urandom_range(0, 2) == 0); bus.id_mem_write = 1'($urandom);
            bus.mem_reg_write = 1'($urandom); bus.mem_write_reg = 5'($urandom_range(0, 3));
            bus.mem_alu_result = $urandom;
            bus.wb_reg_write = 1'($urandom); bus.wb_write_reg = 5'($urandom_range(0, 3));
            bus.wb_result = $urandom;
            bus.flush_e = ($urandom_range(0, 7) == 0);
            #1;
            exp_b = ex.alu_src ? ex.imm : model_operand(ex.rt, ex.rd2);
            if (bus.src_a !== model_operand(ex.rs, ex.rd1)) begin
                errors++; $display("FAIL rand_src_a cycle %0d got %h want %h", i, bus.src_a, model_operand(ex.rs, ex.rd1));
            end
            checks++;
            if (bus.src_b !== exp_b || bus.ex_write_data !== model_operand(ex.rt, ex.rd2)) begin
                errors++; $display("FAIL rand_src_b cycle %0d got b=%h wd=%h want %h %h", i,
                    bus.src_b, bus.ex_write_data, exp_b, model_operand(ex.rt, ex.rd2));
            end
            checks++;
            if (bus.stall_f !== model_stall() || bus.stall_d !== model_stall()) begin
                errors++; $display("FAIL rand_stall cycle %0d got f=%b d=%b want %b", i,
                    bus.stall_f, bus.stall_d, model_stall());
            end
            checks++;
            if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_write,
                 bus.alu_control, bus.ex_write_reg} !==
                {ex.valid, ex.reg_write, ex.mem_to_reg, ex.mem_write, ex.alu_control, ex.wreg}) begin
                errors++; $display("FAIL rand_regs cycle %0d got %b want %b", i,
                    {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_to_reg, bus.ex_mem_write,
                     bus.alu_control, bus.ex_write_reg},
                    {ex.valid, ex.reg_write, ex.mem_to_reg, ex.mem_write, ex.alu_control, ex.wreg});
            end
            checks++;
            tick();
        end
        reset = 0;
    endtask

    initial begin
        ex = empty_slot();
        reset = 1;
        idle();
        test_reset();
        test_forward_priority();
        test_zero_index();
        test_load_use();
        test_load_use_flush();
        test_imm_store();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
